// File: rtl/trigger_conditioner.sv
// trigger_conditioner
//   Conditions an asynchronous trigger into a single capture-start pulse.
//   The raw trigger is synchronized, an edge/level condition is selected, and
//   a three-state FSM (IDLE / ARMED / HOLDOFF) turns the first qualifying
//   condition after an arm request into one pulse, followed by a programmable
//   holdoff. A saturating 32-bit counter tallies the pulses.
//
// Ports
//   clk_usb       sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   reg_address   register address
//   reg_bytecnt   byte index within a multi-byte register
//   reg_datai     register write data
//   reg_datao     registered read data (0 when not reading)
//   reg_read      read strobe
//   reg_write     write strobe
//   trigger_i     combined trigger, asynchronous to clk_usb
//   arm_i         one-cycle arm request
//   trig_start_o  one-cycle capture-start pulse
//   armed_o       high while the FSM is ARMED
//
// Registers
//   pCFG_ADDR      [1:0] mode, [2] enable, [3] auto-rearm, [7:4] read 0
//   pHOLDOFF_ADDR  16-bit holdoff length, LSB first
//   pCOUNT_ADDR    32-bit pulse count, LSB first; any write clears it
//   pSTATUS_ADDR   {5'b0, synchronized trigger, state[1:0]}

module trigger_conditioner #(
    parameter int         pBYTECNT_SIZE = 7,
    parameter logic [7:0] pCFG_ADDR     = 8'h70,
    parameter logic [7:0] pHOLDOFF_ADDR = 8'h71,
    parameter logic [7:0] pCOUNT_ADDR   = 8'h72,
    parameter logic [7:0] pSTATUS_ADDR  = 8'h73
) (
    input  logic                     clk_usb,
    input  logic                     reset_n,
    input  logic [7:0]               reg_address,
    input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    input  logic [7:0]               reg_datai,
    output logic [7:0]               reg_datao,
    input  logic                     reg_read,
    input  logic                     reg_write,
    input  logic                     trigger_i,
    input  logic                     arm_i,
    output logic                     trig_start_o,
    output logic                     armed_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        HOLDOFF = 2'b10
    } state_t;

    state_t      state;
    logic        s1, s2, s3;
    logic [3:0]  cfg;
    logic [15:0] holdoff;
    logic [15:0] hold_cnt;
    logic [31:0] trig_count;
    logic        cond;
    logic        en_eff;
    logic        wr_cfg, wr_hold, wr_count;
    logic [7:0]  rd_byte;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign wr_cfg   = reg_write && (reg_address == pCFG_ADDR);
    assign wr_hold  = reg_write && (reg_address == pHOLDOFF_ADDR);
    assign wr_count = reg_write && (reg_address == pCOUNT_ADDR);

    // A CFG write landing on this edge already governs the FSM, so clearing
    // enable beats a condition that is true on the same edge.
    assign en_eff = wr_cfg ? reg_datai[2] : cfg[2];

    // Synchronizer stage: s1/s2 resynchronize, s3 is history for edge detect
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= trigger_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        cond = 1'b0;
        case (cfg[1:0])
            2'b00:   cond = s2 & ~s3;
            2'b01:   cond = ~s2 & s3;
            2'b10:   cond = s2 ^ s3;
            default: cond = s2;
        endcase
    end

    // Configuration registers
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            cfg     <= 4'h4;
            holdoff <= 16'h0000;
        end else begin
            if (wr_cfg)
                cfg <= reg_datai[3:0];
            if (wr_hold) begin
                if (reg_bytecnt == pBYTECNT_SIZE'(0))
                    holdoff[7:0] <= reg_datai;
                else if (reg_bytecnt == pBYTECNT_SIZE'(1))
                    holdoff[15:8] <= reg_datai;
            end
        end
    end

    // FSM stage: outputs are registered alongside the state so armed_o
    // tracks state exactly and trig_start_o is the cycle after the decision.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            hold_cnt     <= 16'h0000;
            trig_start_o <= 1'b0;
            armed_o      <= 1'b0;
        end else begin
            trig_start_o <= 1'b0;
            if (!en_eff) begin
                state    <= IDLE;
                hold_cnt <= 16'h0000;
                armed_o  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm_i) begin
                            state   <= ARMED;
                            armed_o <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (cond) begin
                            state        <= HOLDOFF;
                            armed_o      <= 1'b0;
                            hold_cnt     <= holdoff;
                            trig_start_o <= 1'b1;
                        end
                    end
                    HOLDOFF: begin
                        // A load of H leaves after H cycles; 0 and 1 both
                        // give the minimum single holdoff cycle.
                        if (hold_cnt <= 16'd1) begin
                            hold_cnt <= 16'h0000;
                            if (cfg[3]) begin
                                state   <= ARMED;
                                armed_o <= 1'b1;
                            end else begin
                                state   <= IDLE;
                                armed_o <= 1'b0;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - 16'd1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        armed_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Pulse counter stage: clear has priority over the increment
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n)
            trig_count <= 32'h0000_0000;
        else if (wr_count)
            trig_count <= 32'h0000_0000;
        else if (trig_start_o)
            trig_count <= sat_inc(trig_count);
    end

    always_comb begin
        rd_byte = 8'h00;
        case (reg_address)
            pCFG_ADDR: begin
                if (reg_bytecnt == pBYTECNT_SIZE'(0))
                    rd_byte = {4'h0, cfg};
            end
            pHOLDOFF_ADDR: begin
                if (reg_bytecnt == pBYTECNT_SIZE'(0))
                    rd_byte = holdoff[7:0];
                else if (reg_bytecnt == pBYTECNT_SIZE'(1))
                    rd_byte = holdoff[15:8];
            end
            pCOUNT_ADDR: begin
                if (reg_bytecnt == pBYTECNT_SIZE'(0))
                    rd_byte = trig_count[7:0];
                else if (reg_bytecnt == pBYTECNT_SIZE'(1))
                    rd_byte = trig_count[15:8];
                else if (reg_bytecnt == pBYTECNT_SIZE'(2))
                    rd_byte = trig_count[23:16];
                else if (reg_bytecnt == pBYTECNT_SIZE'(3))
                    rd_byte = trig_count[31:24];
            end
            pSTATUS_ADDR: begin
                if (reg_bytecnt == pBYTECNT_SIZE'(0))
                    rd_byte = {5'b00000, s2, state};
            end
            default: rd_byte = 8'h00;
        endcase
    end

    // Read-data stage
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n)
            reg_datao <= 8'h00;
        else if (reg_read)
            reg_datao <= rd_byte;
        else
            reg_datao <= 8'h00;
    end

endmodule

// File: tb/tb_trigger_conditioner.sv
// tb_trigger_conditioner
//   Directed bench for trigger_conditioner. Inputs change and outputs are
//   sampled on the falling edge of clk_usb; every expected value below is
//   worked out by hand from the synchronizer/FSM timing.

module tb_trigger_conditioner;

    localparam logic [7:0] CFG_A    = 8'h70;
    localparam logic [7:0] HOLD_A   = 8'h71;
    localparam logic [7:0] COUNT_A  = 8'h72;
    localparam logic [7:0] STATUS_A = 8'h73;

    logic       clk_usb = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] reg_address = 8'h00;
    logic [6:0] reg_bytecnt = 7'd0;
    logic [7:0] reg_datai = 8'h00;
    logic [7:0] reg_datao;
    logic       reg_read = 1'b0;
    logic       reg_write = 1'b0;
    logic       trigger_i = 1'b0;
    logic       arm_i = 1'b0;
    logic       trig_start_o;
    logic       armed_o;

    int n_tests = 0;
    int n_fail  = 0;

    trigger_conditioner dut (
        .clk_usb      (clk_usb),
        .reset_n      (reset_n),
        .reg_address  (reg_address),
        .reg_bytecnt  (reg_bytecnt),
        .reg_datai    (reg_datai),
        .reg_datao    (reg_datao),
        .reg_read     (reg_read),
        .reg_write    (reg_write),
        .trigger_i    (trigger_i),
        .arm_i        (arm_i),
        .trig_start_o (trig_start_o),
        .armed_o      (armed_o)
    );

    always #5 clk_usb = ~clk_usb;

    task automatic cyc();
        @(negedge clk_usb);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [6:0] b, input logic [7:0] d);
        reg_address = a;
        reg_bytecnt = b;
        reg_datai   = d;
        reg_write   = 1'b1;
        cyc();
        reg_write   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [6:0] b, output logic [7:0] d);
        reg_address = a;
        reg_bytecnt = b;
        reg_read    = 1'b1;
        cyc();
        d = reg_datao;
        reg_read = 1'b0;
    endtask

    task automatic rd_count(output logic [31:0] v);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            rd(COUNT_A, 7'(i), b);
            v[i*8 +: 8] = b;
        end
    endtask

    task automatic arm();
        arm_i = 1'b1;
        cyc();
        arm_i = 1'b0;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic [31:0] c;
        int          pulses;
        int          adj;
        logic        prev;

        // ---------------- reset defaults
        #2 reset_n = 1'b0;
        cyc();
        cyc();
        chk("rst_trig", trig_start_o, 0);
        chk("rst_armed", armed_o, 0);
        chk("rst_datao", reg_datao, 0);
        reset_n = 1'b1;
        cyc();
        rd(CFG_A, 0, d);    chk("cfg_default", d, 8'h04);
        rd(STATUS_A, 0, d); chk("status_default", d, 8'h00);
        rd(HOLD_A, 0, d);   chk("hold_default_lo", d, 8'h00);

        // ---------------- basic latency: trigger set before edge N,
        // pulse seen after edge N+2 only
        arm();
        chk("armed_after_arm", armed_o, 1);
        trigger_i = 1'b1;
        cyc(); chk("lat_n", trig_start_o, 0);
        cyc(); chk("lat_n1", trig_start_o, 0);
        cyc(); chk("lat_n2", trig_start_o, 1);
        chk("armed_fall", armed_o, 0);
        cyc(); chk("lat_n3", trig_start_o, 0);
        trigger_i = 1'b0;
        repeat (3) cyc();
        rd_count(c);        chk("count_one", c, 1);
        rd(STATUS_A, 0, d); chk("status_idle", d, 8'h00);

        // ---------------- holdoff 5 with auto-rearm
        wr(COUNT_A, 0, 8'h00);
        wr(HOLD_A, 0, 8'd5);
        wr(HOLD_A, 1, 8'd0);
        wr(CFG_A, 0, 8'h0C);
        arm();
        trigger_i = 1'b1;
        cyc(); trigger_i = 1'b0; chk("ho_p1", trig_start_o, 0);
        cyc(); chk("ho_p2", trig_start_o, 0);
        cyc(); chk("ho_p3", trig_start_o, 1); chk("ho_armed_p3", armed_o, 0);
        trigger_i = 1'b1;  // second rising edge, 3 cycles after the first
        cyc(); trigger_i = 1'b0; chk("ho_p4", trig_start_o, 0);
        for (int k = 5; k <= 8; k++) begin
            cyc();
            chk("ho_no_pulse", trig_start_o, 0);
            chk("ho_armed", armed_o, (k == 8) ? 1 : 0);
        end
        trigger_i = 1'b1;
        repeat (3) cyc();
        chk("ho_third_pulse", trig_start_o, 1);
        trigger_i = 1'b0;
        repeat (8) cyc();
        rd_count(c); chk("count_two", c, 2);

        // ---------------- either-edge mode, holdoff 0, auto-rearm.
        // The trigger is held two cycles so its falling edge arrives after
        // the single holdoff cycle that follows the rising-edge pulse.
        wr(HOLD_A, 0, 8'd0);
        wr(CFG_A, 0, 8'h0E);
        pulses = 0; adj = 0; prev = 1'b0;
        trigger_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 2) trigger_i = 1'b0;
            if (trig_start_o) begin
                pulses++;
                if (prev) adj++;
            end
            prev = trig_start_o;
        end
        chk("either_pulses", pulses, 2);
        chk("either_adjacent", adj, 0);

        // ---------------- level-high mode: one pulse every 2 cycles
        wr(CFG_A, 0, 8'h0F);
        trigger_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("level_pattern", trig_start_o, (k >= 3 && (k % 2) == 1) ? 1 : 0);
        end
        trigger_i = 1'b0;
        repeat (4) cyc();

        // ---------------- disable written on the same edge as a true condition
        wr(CFG_A, 0, 8'h04);
        trigger_i = 1'b1;
        cyc();
        cyc();
        wr(CFG_A, 0, 8'h00);
        chk("dis_trig", trig_start_o, 0);
        chk("dis_armed", armed_o, 0);
        cyc(); chk("dis_trig_later", trig_start_o, 0);
        rd(STATUS_A, 0, d); chk("dis_status_s2", d, 8'h04);
        arm();
        chk("dis_arm_ignored", armed_o, 0);
        trigger_i = 1'b0;
        repeat (3) cyc();
        rd(STATUS_A, 0, d); chk("dis_status", d, 8'h00);
        rd(CFG_A, 0, d);    chk("dis_cfg", d, 8'h00);

        // ---------------- count saturation and clear-over-increment
        wr(CFG_A, 0, 8'h0C);
        arm();
        chk("sat_armed", armed_o, 1);
        force dut.trig_count = 32'hFFFF_FFFE;
        #1;
        release dut.trig_count;
        for (int p = 0; p < 2; p++) begin
            trigger_i = 1'b1;
            repeat (3) cyc();
            chk("sat_pulse", trig_start_o, 1);
            trigger_i = 1'b0;
            repeat (4) cyc();
        end
        rd_count(c); chk("count_saturated", c, 32'hFFFF_FFFF);
        trigger_i = 1'b1;
        repeat (3) cyc();
        chk("clr_pulse", trig_start_o, 1);
        wr(COUNT_A, 0, 8'h00);
        trigger_i = 1'b0;
        repeat (3) cyc();
        rd_count(c); chk("count_cleared", c, 0);

        // ---------------- register boundaries
        wr(HOLD_A, 0, 8'd20);
        rd(HOLD_A, 0, d);   chk("hold_lo", d, 8'h14);
        rd(HOLD_A, 2, d);   chk("hold_beyond", d, 8'h00);
        wr(CFG_A, 0, 8'hF4);
        rd(CFG_A, 0, d);    chk("cfg_reserved", d, 8'h04);
        rd(CFG_A, 1, d);    chk("cfg_beyond", d, 8'h00);
        rd(8'h10, 0, d);    chk("unknown_addr", d, 8'h00);
        cyc();              chk("no_read_datao", reg_datao, 8'h00);

        // ---------------- reset mid-pulse / mid-holdoff
        trigger_i = 1'b1;
        cyc();
        cyc();
        reg_address = STATUS_A;
        reg_bytecnt = 7'd0;
        reg_read    = 1'b1;
        cyc();
        chk("pre_rst_trig", trig_start_o, 1);
        chk("pre_rst_status", reg_datao, 8'h05);
        reset_n = 1'b0;
        #1;
        chk("rst_async_trig", trig_start_o, 0);
        chk("rst_async_armed", armed_o, 0);
        chk("rst_async_datao", reg_datao, 8'h00);
        reg_read = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 4) trigger_i = 1'b0;
            if (k == 6) trigger_i = 1'b1;
            if (trig_start_o) pulses++;
        end
        chk("post_rst_pulses", pulses, 0);
        chk("post_rst_armed", armed_o, 0);
        rd(CFG_A, 0, d);  chk("post_rst_cfg", d, 8'h04);
        rd(HOLD_A, 0, d); chk("post_rst_hold", d, 8'h00);
        rd_count(c);      chk("post_rst_count", c, 0);
        arm();
        chk("rearm_armed", armed_o, 1);
        trigger_i = 1'b0;
        repeat (3) cyc();
        trigger_i = 1'b1;
        repeat (3) cyc();
        chk("rearm_pulse", trig_start_o, 1);
        trigger_i = 1'b0;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
